// File: rtl/switch_debounce_pair_pkg.sv
// Shared constants and types for the board's switch-facing logic.
// Other switch-handling blocks reuse the clock frequency and default
// debounce window defined here.
package switch_debounce_pair_pkg;

  // Board oscillator frequency.
  localparam int CLK_FREQ_HZ = 25_000_000;

  // Debounce window length in milliseconds.
  localparam int DEBOUNCE_MS = 10;

  // Default debounce window in clock cycles (10 ms at 25 MHz = 250000).
  localparam int DEFAULT_DEBOUNCE_LIMIT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

  // Counter width large enough for the default window.
  localparam int DEFAULT_CNT_W = 18;

  // Debounce state of one channel. It is not stored anywhere: it is
  // decoded from whether the synchronized input matches the stable level.
  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

  // True when a counter of 'width' bits can hold every value 0..limit-1.
  function automatic bit cnt_fits(input int limit, input int width);
    return (longint'(1) << width) >= longint'(limit);
  endfunction

endpackage

// File: rtl/switch_debounce_pair_debounce_channel.sv
// One switch conditioner: 2-flop synchronizer, hold-time counter,
// stable level and a registered output stage that produces the
// level together with its one-cycle rise/fall pulses.
module debounce_channel
  import switch_debounce_pair_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_switch,
  output logic o_switch,
  output logic o_rise,
  output logic o_fall
);

  // Last count value before the new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             stable_reg;
  logic             stable_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             out_reg;
  logic             rise_reg;
  logic             fall_reg;
  db_state_e        state;

  // Two-flop synchronizer for the raw asynchronous switch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= i_switch;
      s2_reg <= s1_reg;
    end
  end

  // Decode state from the stable level and compute the next count/level.
  // Any return to the stable value clears the count, so bounces never
  // accumulate toward the limit.
  always_comb begin
    stable_next = stable_reg;
    cnt_next    = '0;
    state       = (s2_reg == stable_reg) ? DB_STABLE : DB_PENDING;
    case (state)
      DB_STABLE: begin
        cnt_next = '0;
      end
      DB_PENDING: begin
        if (cnt_reg == CNT_LAST) begin
          stable_next = s2_reg;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        cnt_next = '0;
      end
    endcase
  end

  // Counter and stable-level registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
    end
  end

  // Output stage: the level and its edge pulse appear in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_reg  <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      out_reg  <= stable_reg;
      rise_reg <= stable_reg & ~out_reg;
      fall_reg <= ~stable_reg & out_reg;
    end
  end

  assign o_switch = out_reg;
  assign o_rise   = rise_reg;
  assign o_fall   = fall_reg;

endmodule

// File: rtl/switch_debounce_pair.sv
// Two-channel switch conditioner feeding the LED demux select lines.
// Both channels are independent debouncers; the top only forms the
// 2-bit select and its change strobe, so the select updates in one step
// even when both channels flip together.
module switch_debounce_pair
  import switch_debounce_pair_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_switch_1,
  input  logic       i_switch_2,
  output logic       o_switch_1,
  output logic       o_switch_2,
  output logic       o_rise_1,
  output logic       o_fall_1,
  output logic       o_rise_2,
  output logic       o_fall_2,
  output logic [1:0] o_sel,
  output logic       o_sel_change
);

  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;

  assign raw = {i_switch_2, i_switch_1};

  // One conditioner per switch; bit 0 is switch 1, bit 1 is switch 2.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      debounce_channel #(
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
        .CNT_W          (CNT_W)
      ) u_ch (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_switch (raw[gi]),
        .o_switch (level[gi]),
        .o_rise   (rise[gi]),
        .o_fall   (fall[gi])
      );
    end
  endgenerate

  assign o_switch_1 = level[0];
  assign o_switch_2 = level[1];
  assign o_rise_1   = rise[0];
  assign o_fall_1   = fall[0];
  assign o_rise_2   = rise[1];
  assign o_fall_2   = fall[1];

  // Select is the pair of debounced levels; the strobe marks any edge.
  assign o_sel        = level;
  assign o_sel_change = |{rise, fall};

endmodule

// File: doc/switch_debounce_pair.md
Name: switch_debounce_pair

Overview:
Two-channel switch conditioner that sits directly upstream of the 1-to-4 LED demux select inputs. It turns raw, bouncing board switches i_switch_1/i_switch_2 into clean, clock-synchronous levels and edge pulses. It also produces a combined 2-bit select with a change strobe, so the demux select never glitches during bounce.

Parameters:
DEBOUNCE_LIMIT, 250000, cycles a synchronized input must hold a new value before the output flips (10 ms at 25 MHz); must be >= 2
CNT_W, 18, counter width; must satisfy 2**CNT_W >= DEBOUNCE_LIMIT

Ports:
i_clk  input  1  system clock, single clock domain
i_rst  input  1  synchronous, active-high reset
i_switch_1  input  1  raw asynchronous switch 1
i_switch_2  input  1  raw asynchronous switch 2
o_switch_1  output  1  debounced level, switch 1
o_switch_2  output  1  debounced level, switch 2
o_rise_1  output  1  one-cycle pulse when o_switch_1 goes 0->1
o_fall_1  output  1  one-cycle pulse when o_switch_1 goes 1->0
o_rise_2  output  1  one-cycle pulse when o_switch_2 goes 0->1
o_fall_2  output  1  one-cycle pulse when o_switch_2 goes 1->0
o_sel  output  2  {o_switch_2, o_switch_1}, feeds demux sel1/sel0
o_sel_change  output  1  one-cycle pulse when o_sel takes a new value

Behaviour:
- Clocking and reset: one clock (i_clk). Reset is synchronous and active-high (i_rst); it is sampled only on the rising edge of i_clk.
- Reset state: sync flops, counters and stable levels are 0. All outputs are 0 in the cycle after reset is sampled. i_rst has priority over every other event.
- Synchronizer: each raw input passes through a 2-flop synchronizer (s1 -> s2). Only s2 is used downstream.
- Per-channel debounce, two states implied by the stable level:
  - STABLE: s2 == stable, so cnt <= 0.
  - PENDING: s2 != stable. If cnt == DEBOUNCE_LIMIT-1, then stable <= s2 and cnt <= 0. Otherwise cnt <= cnt+1.
- Bounce rejection: if s2 returns to the stable value before the limit is reached, cnt clears to 0. There is no accumulation across bounces.
- Latency: a clean input step appears on o_switch_N exactly 2 + DEBOUNCE_LIMIT cycles after the raw edge is first sampled. This is measured from the first i_clk edge that samples the new raw value to the first cycle o_switch_N shows it.
- Edge pulses:
  - o_rise_N / o_fall_N are registered and asserted for exactly the one cycle in which o_switch_N first shows the new value.
  - o_rise_N and o_fall_N are never both high.
- Select outputs:
  - o_sel is the concatenation of the stable levels, with no extra latency.
  - o_sel_change = o_rise_1|o_fall_1|o_rise_2|o_fall_2, aligned with the o_sel update.
  - If both channels flip in the same cycle, one o_sel_change pulse is produced and o_sel jumps directly to its final value. No intermediate code is allowed.
- Counter saturation: cnt never exceeds DEBOUNCE_LIMIT-1, so there is no wrap-around.
- Reset mid-count: reset discards pending counts. After release, an input held at 1 needs the full 2 + DEBOUNCE_LIMIT cycles and then produces a rise pulse.
- Steady-state input: an input held constant for any length of time produces no pulses.

Decomposition:
- Shared constants file holds the board clock frequency (25_000_000) and the default 10 ms DEBOUNCE_LIMIT derived from it. Other switch-facing blocks reuse these.
- One natural sub-module: debounce_channel (synchronizer, counter, stable level, rise/fall pulse), instantiated twice.
- The top level contains only the o_sel concatenation and the o_sel_change OR.

Test Plan:
All scenarios use DEBOUNCE_LIMIT=8.
- Reset: hold i_rst for 3 cycles with both switches=1 -> all outputs 0 during reset and in the first cycle after; o_switch_1=o_switch_2=1 at cycle 10 after release, with o_rise_1, o_rise_2 and one o_sel_change pulse; o_sel=2'b11.
- Clean step: i_switch_1 goes 0->1 and holds -> o_switch_1 rises exactly 10 cycles later; o_rise_1 high for 1 cycle; o_sel=2'b01; o_sel_change pulses once.
- Bounce: i_switch_2 toggles with high widths 3,5,7 and low gaps 2, then holds 1 -> no output change during the bounce; o_switch_2 rises 10 cycles after the final rising edge; exactly one o_rise_2.
- Falling edge: from o_sel=2'b11, drop i_switch_1 -> after 10 cycles o_fall_1 pulses once; o_sel=2'b10; o_rise_1 stays 0.
- Simultaneous: both switches step 0->1 on the same edge -> both rise pulses occur in the same cycle; one o_sel_change; o_sel goes 00->11 with no 01 or 10 visible.
- Reset mid-count: switch_1 held 1; assert i_rst at count 5 -> o_switch_1 stays 0; after release it rises a full 10 cycles later.
